// File: rtl/ma_wb_regfile.sv
// ma_wb_regfile: MA/WB pipeline latch plus a 32-entry register file with two combinational read ports.
// Read ports forward from the EX/MA and MA/WB stages when BYPASS is nonzero.
`default_nettype none

module ma_wb_regfile #(
  parameter int WORD_WIDTH = 32,
  parameter int BYPASS     = 1
) (
  input  logic                  CLK,
  input  logic                  RST_n,
  input  logic [WORD_WIDTH-1:0] C_1,
  input  logic [4:0]            Addr_1,
  input  logic                  WE_1,
  input  logic [4:0]            RA_Addr,
  input  logic [4:0]            RB_Addr,
  output logic [WORD_WIDTH-1:0] RA_Data,
  output logic [WORD_WIDTH-1:0] RB_Data,
  output logic [WORD_WIDTH-1:0] C_2,
  output logic [4:0]            Addr_2,
  output logic                  WE_2
);

  localparam logic BYPASS_EN = (BYPASS != 0);

  logic [WORD_WIDTH-1:0] regs [0:31];
  logic                  wb_en;

  assign wb_en = WE_2 && (Addr_2 != 5'd0);

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      C_2    <= '0;
      Addr_2 <= '0;
      WE_2   <= 1'b0;
    end else begin
      C_2    <= C_1;
      Addr_2 <= Addr_1;
      WE_2   <= WE_1;
    end
  end

  // Entry 0 is cleared on reset and never written, so it stays zero.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_en) begin
      regs[Addr_2] <= C_2;
    end
  end

  // Youngest producer wins: EX/MA, then MA/WB, then the array.
  function automatic logic [WORD_WIDTH-1:0] read_port(
    input logic [4:0]            addr,
    input logic                  we1,
    input logic [4:0]            addr1,
    input logic [WORD_WIDTH-1:0] c1,
    input logic                  we2,
    input logic [4:0]            addr2,
    input logic [WORD_WIDTH-1:0] c2,
    input logic [WORD_WIDTH-1:0] arr
  );
    logic [WORD_WIDTH-1:0] data;
    data = arr;
    if (addr == 5'd0) begin
      data = '0;
    end else if (BYPASS_EN && we1 && (addr1 == addr)) begin
      data = c1;
    end else if (BYPASS_EN && we2 && (addr2 == addr)) begin
      data = c2;
    end
    return data;
  endfunction

  always_comb begin
    RA_Data = '0;
    RB_Data = '0;
    RA_Data = read_port(RA_Addr, WE_1, Addr_1, C_1, WE_2, Addr_2, C_2, regs[RA_Addr]);
    RB_Data = read_port(RB_Addr, WE_1, Addr_1, C_1, WE_2, Addr_2, C_2, regs[RB_Addr]);
  end

endmodule

`default_nettype wire

// File: tb/tb_ma_wb_regfile.sv
// tb_ma_wb_regfile: directed stimulus into a bypassing and a non-bypassing instance; scoreboard queue checked at negedge.
`default_nettype none

module tb_ma_wb_regfile;

  logic        CLK = 1'b0;
  logic        RST_n = 1'b0;
  logic [31:0] C_1 = '0;
  logic [4:0]  Addr_1 = '0;
  logic        WE_1 = 1'b0;
  logic [4:0]  RA_Addr = '0;
  logic [4:0]  RB_Addr = '0;

  logic [31:0] b_ra, b_rb, b_c2, n_ra, n_rb, n_c2;
  logic [4:0]  b_a2, n_a2;
  logic        b_we2, n_we2;

  int tests  = 0;
  int failed = 0;

  always #5 CLK = ~CLK;

  ma_wb_regfile #(.WORD_WIDTH(32), .BYPASS(1)) dut_byp (
    .CLK(CLK), .RST_n(RST_n), .C_1(C_1), .Addr_1(Addr_1), .WE_1(WE_1),
    .RA_Addr(RA_Addr), .RB_Addr(RB_Addr), .RA_Data(b_ra), .RB_Data(b_rb),
    .C_2(b_c2), .Addr_2(b_a2), .WE_2(b_we2)
  );

  ma_wb_regfile #(.WORD_WIDTH(32), .BYPASS(0)) dut_nob (
    .CLK(CLK), .RST_n(RST_n), .C_1(C_1), .Addr_1(Addr_1), .WE_1(WE_1),
    .RA_Addr(RA_Addr), .RB_Addr(RB_Addr), .RA_Data(n_ra), .RB_Data(n_rb),
    .C_2(n_c2), .Addr_2(n_a2), .WE_2(n_we2)
  );

  typedef struct {
    int          sel;
    logic [31:0] exp;
  } item_t;

  item_t sbq[$];

  function automatic logic [31:0] pick(input int sel);
    case (sel)
      0: return b_ra;
      1: return b_rb;
      2: return n_ra;
      3: return n_rb;
      4: return b_c2;
      5: return {27'd0, b_a2};
      6: return {31'd0, b_we2};
      7: return n_c2;
      8: return {27'd0, n_a2};
      default: return {31'd0, n_we2};
    endcase
  endfunction

  function automatic string name(input int sel);
    case (sel)
      0: return "byp.RA_Data";
      1: return "byp.RB_Data";
      2: return "nob.RA_Data";
      3: return "nob.RB_Data";
      4: return "byp.C_2";
      5: return "byp.Addr_2";
      6: return "byp.WE_2";
      7: return "nob.C_2";
      8: return "nob.Addr_2";
      default: return "nob.WE_2";
    endcase
  endfunction

  // Monitor: everything queued for the current cycle is compared at the falling edge.
  always @(negedge CLK) begin
    while (sbq.size() > 0) begin
      item_t it;
      logic [31:0] act;
      it  = sbq.pop_front();
      act = pick(it.sel);
      tests++;
      if (act !== it.exp) begin
        failed++;
        $display("FAIL %s t=%0t: got %h, expected %h", name(it.sel), $time, act, it.exp);
      end
    end
  end

  task automatic push(input int sel, input logic [31:0] v);
    item_t it;
    it.sel = sel;
    it.exp = v;
    sbq.push_back(it);
  endtask

  task automatic step(input logic [31:0] c, input logic [4:0] a, input logic we,
                      input logic [4:0] ra, input logic [4:0] rb);
    @(posedge CLK);
    #1;
    C_1 = c; Addr_1 = a; WE_1 = we; RA_Addr = ra; RB_Addr = rb;
  endtask

  task automatic chk_rd(input logic [31:0] ba, input logic [31:0] bb,
                        input logic [31:0] na, input logic [31:0] nb);
    push(0, ba); push(1, bb); push(2, na); push(3, nb);
  endtask

  task automatic chk_latch(input logic [31:0] c2, input logic [4:0] a2, input logic we2);
    push(4, c2); push(5, {27'd0, a2}); push(6, {31'd0, we2});
    push(7, c2); push(8, {27'd0, a2}); push(9, {31'd0, we2});
  endtask

  initial begin
    // Held in reset from time 0.
    step(32'h0, 5'd0, 1'b0, 5'd5, 5'd5);
    chk_rd(0, 0, 0, 0);
    chk_latch(0, 0, 1'b0);
    @(negedge CLK); #2 RST_n = 1'b1;

    // Write-back latency on r7.
    step(32'h12345678, 5'd7, 1'b1, 5'd7, 5'd7);
    chk_rd(32'h12345678, 32'h12345678, 0, 0);
    step(32'h0, 5'd0, 1'b0, 5'd7, 5'd7);
    chk_rd(32'h12345678, 32'h12345678, 0, 0);
    chk_latch(32'h12345678, 5'd7, 1'b1);
    step(32'h0, 5'd0, 1'b0, 5'd7, 5'd0);
    chk_rd(32'h12345678, 0, 32'h12345678, 0);
    chk_latch(0, 0, 1'b0);

    // Two back-to-back writes to r3.
    step(32'hA, 5'd3, 1'b1, 5'd3, 5'd3);
    chk_rd(32'hA, 32'hA, 0, 0);
    step(32'hB, 5'd3, 1'b1, 5'd3, 5'd3);
    chk_rd(32'hB, 32'hB, 0, 0);
    step(32'h0, 5'd0, 1'b0, 5'd3, 5'd3);
    chk_rd(32'hB, 32'hB, 32'hA, 32'hA);
    step(32'h0, 5'd0, 1'b0, 5'd3, 5'd3);
    chk_rd(32'hB, 32'hB, 32'hB, 32'hB);

    // Writes targeting r0 never surface.
    for (int i = 0; i < 3; i++) begin
      step(32'hFFFFFFFF, 5'd0, 1'b1, 5'd0, 5'd0);
      chk_rd(0, 0, 0, 0);
    end
    chk_latch(32'hFFFFFFFF, 5'd0, 1'b1);
    step(32'h0, 5'd0, 1'b0, 5'd0, 5'd0);
    chk_rd(0, 0, 0, 0);

    // Bubble aimed at r9 must not disturb it.
    step(32'h77, 5'd9, 1'b1, 5'd0, 5'd0);
    step(32'h0, 5'd0, 1'b0, 5'd0, 5'd0);
    step(32'h55, 5'd9, 1'b0, 5'd9, 5'd9);
    chk_rd(32'h77, 32'h77, 32'h77, 32'h77);
    step(32'h55, 5'd9, 1'b0, 5'd9, 5'd9);
    chk_rd(32'h77, 32'h77, 32'h77, 32'h77);
    chk_latch(32'h55, 5'd9, 1'b0);
    step(32'h0, 5'd0, 1'b0, 5'd9, 5'd9);
    chk_rd(32'h77, 32'h77, 32'h77, 32'h77);

    // Independent ports, one of them hitting a bypass.
    step(32'h11, 5'd1, 1'b1, 5'd0, 5'd0);
    step(32'h22, 5'd2, 1'b1, 5'd0, 5'd0);
    step(32'h0, 5'd0, 1'b0, 5'd0, 5'd0);
    step(32'h0, 5'd0, 1'b0, 5'd1, 5'd2);
    chk_rd(32'h11, 32'h22, 32'h11, 32'h22);
    step(32'h99, 5'd2, 1'b1, 5'd1, 5'd2);
    chk_rd(32'h11, 32'h99, 32'h11, 32'h22);
    step(32'h0, 5'd0, 1'b0, 5'd2, 5'd2);
    chk_rd(32'h99, 32'h99, 32'h22, 32'h22);

    // Mid-cycle reset clears the array and drops a pending write.
    step(32'hDEADBEEF, 5'd5, 1'b1, 5'd0, 5'd0);
    step(32'h0, 5'd0, 1'b0, 5'd0, 5'd0);
    step(32'h0, 5'd0, 1'b0, 5'd5, 5'd5);
    chk_rd(32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
    step(32'h66, 5'd6, 1'b1, 5'd5, 5'd6);
    chk_rd(32'hDEADBEEF, 32'h66, 32'hDEADBEEF, 32'h0);
    step(32'h0, 5'd0, 1'b0, 5'd5, 5'd6);
    #2 RST_n = 1'b0;
    chk_rd(0, 0, 0, 0);
    chk_latch(0, 0, 1'b0);
    @(negedge CLK); #2 RST_n = 1'b1;
    step(32'h0, 5'd0, 1'b0, 5'd5, 5'd6);
    chk_rd(0, 0, 0, 0);
    step(32'h0, 5'd0, 1'b0, 5'd5, 5'd6);
    chk_rd(0, 0, 0, 0);
    chk_latch(0, 0, 1'b0);

    @(negedge CLK);
    #1;
    if (sbq.size() != 0) begin
      tests++;
      failed++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
